sync_fifo_core: RTL and testbench
=================================

// Module: sync_fifo_core
// PURPOSE
//  Single-clock synchronous FIFO with XPM/DCFIFO-style status outputs, sitting in the packet datapath
//  wherever producer and consumer share one clock (same port semantics as the dual-clock wrapper).
//  Buffers DATA_WIDTH-bit words. Supports standard read (1-cycle latency) or first-word-fall-through.
//  Status outputs: full/empty, almost flags, programmable thresholds, handshake pulses and occupancy count.
// PARAMETERS
//  DATA_WIDTH        32            word width in bits
//  FIFO_DEPTH        2048          capacity in words; power of 2, >=4
//  ADDR_WIDTH        $clog2(DEPTH) pointer width (derived)
//  FWFT_MODE         1             1 = first-word-fall-through, 0 = standard read
//  PROG_FULL_THRESH  10            prog_full when data_count >= value (1..DEPTH-1)
//  PROG_EMPTY_THRESH 10            prog_empty when data_count <= value (1..DEPTH-1)
// PORTS
//  clk           in   1             single clock, all logic rising-edge
//  rst           in   1             synchronous reset, active-high
//  wr_en         in   1             write request
//  wr_data       in   DATA_WIDTH    write word
//  full          out  1             data_count == FIFO_DEPTH
//  almost_full   out  1             data_count >= FIFO_DEPTH-1
//  prog_full     out  1             data_count >= PROG_FULL_THRESH
//  wr_ack        out  1             1-cycle pulse: previous-cycle write accepted
//  overflow      out  1             1-cycle pulse: previous-cycle write rejected
//  rd_en         in   1             read request / pop
//  rd_data       out  DATA_WIDTH    read word
//  empty         out  1             no word available to read
//  almost_empty  out  1             data_count <= 1
//  prog_empty    out  1             data_count <= PROG_EMPTY_THRESH
//  rd_valid      out  1             rd_data valid (see modes)
//  underflow     out  1             1-cycle pulse: previous-cycle read rejected
//  data_count    out  ADDR_WIDTH+1  words held, including FWFT output stage, 0..FIFO_DEPTH
//  rst_busy      out  1             high during rst and 1 cycle after release
// BEHAVIOUR
//  Reset (sync): all outputs are registered with these values.
//   - Low: ptrs, data_count, full, almost_full, prog_full, rd_valid, rd_data, wr_ack, overflow, underflow.
//   - High: empty, almost_empty, prog_empty, rst_busy.
//   - Contents are discarded. A mid-operation reset takes priority over any concurrent wr_en/rd_en.
//  rst_busy: 1 while rst, and 1 for the first cycle after rst falls. wr_en/rd_en are ignored while rst_busy=1 (no pulses).
//  Write accept: wr_en && !full && !rst_busy, at edge N.
//   - wr_ack=1 during cycle N+1. A write with full=1 drops data; overflow=1 during N+1.
//   - A write is rejected while full even if a read is accepted in the same cycle.
//  Read accept: rd_en && !empty && !rst_busy. rd_en with empty=1 -> underflow=1 next cycle, state unchanged.
//  Simultaneous accepted write+read: data_count unchanged; writing to an empty FIFO never satisfies the same-cycle read.
//  data_count and all flags are updated at the same edge as the accepted op (computed from next count).
//  Pointers wrap modulo FIFO_DEPTH. Full and empty are decided by the count/extra pointer bit, never ambiguous.
//  Standard mode (FWFT_MODE=0):
//   - Write at edge N -> empty=0 from N+1.
//   - Read accepted at edge M -> rd_data = head word and rd_valid=1 during M+1.
//   - rd_valid=0 otherwise; rd_data holds its last value.
//  FWFT mode (FWFT_MODE=1):
//   - Head word is presented on rd_data with rd_valid=1, empty=0 (empty == ~rd_valid).
//   - A word written into an empty FIFO at edge N is presented after edge N+1.
//   - rd_en while rd_valid pops at that edge; the next stored word is presented after the same edge (no bubble).
//   - With no next word, rd_valid falls.
//   - Memory: inferred simple dual-port array, registered read, no output reset other than the rd_data register.
// TESTING
//  1. Reset, then release: rst_busy 1 for one cycle after release; empty=1, full=0, data_count=0; wr_en during busy is ignored.
//  2. FWFT, write 0xA5A5_0001..0004 on consecutive cycles, then hold rd_en:
//     - First word is valid 2 cycles after its write.
//     - The 4 words read in order without gaps; empty returns to 1.
//  3. Standard mode, fill DEPTH words:
//     - full=1, almost_full=1, data_count=DEPTH.
//     - Next write -> overflow pulse and no wr_ack; read back all words intact.
//  4. Read while empty -> underflow 1-cycle pulse, data_count stays 0, rd_valid stays 0.
//  5. With data_count=10, simultaneous wr_en+rd_en for 20 cycles:
//     - Count stays 10, prog_full=1 and prog_empty=1 (thresholds 10).
//     - Data order is preserved.
//  6. Assert rst mid-stream with count=7 and wr_en=1 -> next cycle count=0, empty=1, no wr_ack.

Source files
------------

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO with XPM-style status flags.
// Standard (1-cycle read latency) or first-word-fall-through output.
module sync_fifo_core #(
   parameter int DATA_WIDTH        = 32,
   parameter int FIFO_DEPTH        = 2048,
   parameter int ADDR_WIDTH        = $clog2(FIFO_DEPTH),
   parameter int FWFT_MODE         = 1,
   parameter int PROG_FULL_THRESH  = 10,
   parameter int PROG_EMPTY_THRESH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  full,
   output logic                  almost_full,
   output logic                  prog_full,
   output logic                  wr_ack,
   output logic                  overflow,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  empty,
   output logic                  almost_empty,
   output logic                  prog_empty,
   output logic                  rd_valid,
   output logic                  underflow,
   output logic [ADDR_WIDTH:0]   data_count,
   output logic                  rst_busy
);

   localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH:0] PF_C    = (ADDR_WIDTH+1)'(PROG_FULL_THRESH);
   localparam logic [ADDR_WIDTH:0] PE_C    = (ADDR_WIDTH+1)'(PROG_EMPTY_THRESH);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

   logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  empty_q, empty_d;
   logic                  full_q, full_d;
   logic                  afull_q, afull_d;
   logic                  pfull_q, pfull_d;
   logic                  aempty_q, aempty_d;
   logic                  pempty_q, pempty_d;
   logic                  wr_ack_q, wr_ack_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic                  rst_busy_q;

   logic                  wr_acc;
   logic                  rd_acc;
   logic                  load;
   logic                  mem_has;
   logic                  quiet;

   // Accept decisions, pointer/count update and next flag values
   always_comb begin
      quiet   = !rst && !rst_busy_q;
      mem_has = (wr_ptr_q != rd_ptr_q);
      wr_acc  = wr_en && !full_q && quiet;
      rd_acc  = rd_en && !empty_q && quiet;
      load    = rd_acc;
      if (FWFT_MODE != 0) begin
         // output stage refills whenever it is free or being popped
         load = (!rd_valid_q || rd_acc) && mem_has && quiet;
      end

      wr_ptr_d = wr_ptr_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + ONE;

      rd_ptr_d  = rd_ptr_q;
      rd_data_d = rd_data_q;
      if (load) begin
         rd_ptr_d  = rd_ptr_q + ONE;
         rd_data_d = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
      end

      cnt_d = cnt_q;
      if (wr_acc && !rd_acc) cnt_d = cnt_q + ONE;
      if (!wr_acc && rd_acc) cnt_d = cnt_q - ONE;

      rd_valid_d = rd_acc;
      empty_d    = (cnt_d == '0);
      if (FWFT_MODE != 0) begin
         rd_valid_d = load ? 1'b1 : (rd_acc ? 1'b0 : rd_valid_q);
         empty_d    = !rd_valid_d;
      end

      full_d   = (cnt_d == DEPTH_C);
      afull_d  = (cnt_d >= DEPTH_C - ONE);
      pfull_d  = (cnt_d >= PF_C);
      aempty_d = (cnt_d <= ONE);
      pempty_d = (cnt_d <= PE_C);
      wr_ack_d = wr_acc;
      ovf_d    = wr_en && full_q && quiet;
      udf_d    = rd_en && empty_q && quiet;
   end

   // Storage array: write port only, no reset on contents
   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
   end

   // Control and status registers, reset overrides everything
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         afull_q    <= 1'b0;
         pfull_q    <= 1'b0;
         aempty_q   <= 1'b1;
         pempty_q   <= 1'b1;
         wr_ack_q   <= 1'b0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
         rst_busy_q <= 1'b1;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         afull_q    <= afull_d;
         pfull_q    <= pfull_d;
         aempty_q   <= aempty_d;
         pempty_q   <= pempty_d;
         wr_ack_q   <= wr_ack_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
         rst_busy_q <= 1'b0;
      end
   end

   assign full         = full_q;
   assign almost_full  = afull_q;
   assign prog_full    = pfull_q;
   assign wr_ack       = wr_ack_q;
   assign overflow     = ovf_q;
   assign rd_data      = rd_data_q;
   assign empty        = empty_q;
   assign almost_empty = aempty_q;
   assign prog_empty   = pempty_q;
   assign rd_valid     = rd_valid_q;
   assign underflow    = udf_q;
   assign data_count   = cnt_q;
   assign rst_busy     = rst_busy_q;

endmodule

// File: tb/tb_sync_fifo_core.sv
// Bench for sync_fifo_core: one FWFT instance and one standard instance,
// both 16 deep with thresholds of 10.
module tb_sync_fifo_core;

   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] fq[$];
   logic [DW-1:0] sq[$];

   // FWFT instance signals
   logic          f_rst, f_wr_en, f_rd_en;
   logic [DW-1:0] f_wr_data, f_rd_data;
   logic          f_full, f_afull, f_pfull, f_wr_ack, f_ovf;
   logic          f_empty, f_aempty, f_pempty, f_rd_valid, f_udf, f_busy;
   logic [AW:0]   f_cnt;

   // standard-read instance signals
   logic          s_rst, s_wr_en, s_rd_en;
   logic [DW-1:0] s_wr_data, s_rd_data;
   logic          s_full, s_afull, s_pfull, s_wr_ack, s_ovf;
   logic          s_empty, s_aempty, s_pempty, s_rd_valid, s_udf, s_busy;
   logic [AW:0]   s_cnt;

   sync_fifo_core #(
      .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW), .FWFT_MODE(1),
      .PROG_FULL_THRESH(10), .PROG_EMPTY_THRESH(10)
   ) u_fwft (
      .clk(clk), .rst(f_rst), .wr_en(f_wr_en), .wr_data(f_wr_data),
      .full(f_full), .almost_full(f_afull), .prog_full(f_pfull),
      .wr_ack(f_wr_ack), .overflow(f_ovf), .rd_en(f_rd_en),
      .rd_data(f_rd_data), .empty(f_empty), .almost_empty(f_aempty),
      .prog_empty(f_pempty), .rd_valid(f_rd_valid), .underflow(f_udf),
      .data_count(f_cnt), .rst_busy(f_busy)
   );

   sync_fifo_core #(
      .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW), .FWFT_MODE(0),
      .PROG_FULL_THRESH(10), .PROG_EMPTY_THRESH(10)
   ) u_std (
      .clk(clk), .rst(s_rst), .wr_en(s_wr_en), .wr_data(s_wr_data),
      .full(s_full), .almost_full(s_afull), .prog_full(s_pfull),
      .wr_ack(s_wr_ack), .overflow(s_ovf), .rd_en(s_rd_en),
      .rd_data(s_rd_data), .empty(s_empty), .almost_empty(s_aempty),
      .prog_empty(s_pempty), .rd_valid(s_rd_valid), .underflow(s_udf),
      .data_count(s_cnt), .rst_busy(s_busy)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      f_rst = 1'b1; s_rst = 1'b1;
      f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = '0;
      s_wr_en = 1'b0; s_rd_en = 1'b0; s_wr_data = '0;
      repeat (3) tick();
      checks++;
      if ({f_busy, f_empty, f_aempty, f_pempty, f_full, f_rd_valid, f_cnt}
          !== {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0}) begin
         failures++;
         $display("FAIL reset_fwft got busy=%b e=%b ae=%b pe=%b f=%b v=%b cnt=%0d exp 1 1 1 1 0 0 0",
                  f_busy, f_empty, f_aempty, f_pempty, f_full, f_rd_valid, f_cnt);
      end
      checks++;
      if ({s_busy, s_empty, s_full, s_afull, s_pfull, s_cnt, s_rd_data}
          !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0}) begin
         failures++;
         $display("FAIL reset_std got busy=%b e=%b f=%b af=%b pf=%b cnt=%0d rd=%h exp 1 1 0 0 0 0 0",
                  s_busy, s_empty, s_full, s_afull, s_pfull, s_cnt, s_rd_data);
      end
      f_rst = 1'b0; s_rst = 1'b0;
      f_wr_en = 1'b1; f_wr_data = 32'h1111_1111;
      s_wr_en = 1'b1; s_wr_data = 32'h2222_2222;
      checks++;
      if ({f_busy, s_busy} !== 2'b11) begin
         failures++;
         $display("FAIL busy_after_release got f=%b s=%b exp 1 1", f_busy, s_busy);
      end
      tick();
      f_wr_en = 1'b0; s_wr_en = 1'b0;
      checks++;
      if ({f_busy, f_cnt, f_wr_ack, f_empty, s_busy, s_cnt, s_wr_ack, s_empty}
          !== {1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL write_during_busy got f:%b/%0d/%b/%b s:%b/%0d/%b/%b exp 0/0/0/1",
                  f_busy, f_cnt, f_wr_ack, f_empty, s_busy, s_cnt, s_wr_ack, s_empty);
      end
   endtask

   task automatic test_fwft_stream;
      for (int i = 0; i < 4; i++) begin
         f_wr_en = 1'b1;
         f_wr_data = 32'hA5A5_0001 + i;
         fq.push_back(f_wr_data);
         tick();
         if (i == 0) begin
            checks++;
            if ({f_rd_valid, f_empty, f_cnt} !== {1'b0, 1'b1, 5'd1}) begin
               failures++;
               $display("FAIL fwft_latency1 got v=%b e=%b cnt=%0d exp 0 1 1",
                        f_rd_valid, f_empty, f_cnt);
            end
         end
         if (i == 1) begin
            checks++;
            if ({f_rd_valid, f_empty, f_rd_data} !== {1'b1, 1'b0, fq[0]}) begin
               failures++;
               $display("FAIL fwft_latency2 got v=%b e=%b d=%h exp 1 0 %h",
                        f_rd_valid, f_empty, f_rd_data, fq[0]);
            end
         end
      end
      f_wr_en = 1'b0;
      f_rd_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (fq.size() == 0 || f_rd_valid !== 1'b1 || f_rd_data !== fq[0]) begin
            failures++;
            $display("FAIL fwft_stream[%0d] got v=%b d=%h exp 1 %h",
                     i, f_rd_valid, f_rd_data, (fq.size() != 0) ? fq[0] : 32'hx);
         end
         tick();
         if (fq.size() != 0) void'(fq.pop_front());
      end
      f_rd_en = 1'b0;
      checks++;
      if ({f_rd_valid, f_empty, f_aempty, f_cnt} !== {1'b0, 1'b1, 1'b1, 5'd0}) begin
         failures++;
         $display("FAIL fwft_drained got v=%b e=%b ae=%b cnt=%0d exp 0 1 1 0",
                  f_rd_valid, f_empty, f_aempty, f_cnt);
      end
   endtask

   task automatic test_std_fill;
      logic [DW-1:0] last;
      last = '0;
      for (int i = 0; i < DEPTH; i++) begin
         s_wr_en = 1'b1;
         s_wr_data = $urandom;
         sq.push_back(s_wr_data);
         tick();
         checks++;
         if ({s_wr_ack, s_cnt} !== {1'b1, 5'(i + 1)}) begin
            failures++;
            $display("FAIL std_fill_ack[%0d] got ack=%b cnt=%0d exp 1 %0d",
                     i, s_wr_ack, s_cnt, i + 1);
         end
         if (i == DEPTH - 2) begin
            checks++;
            if ({s_full, s_afull} !== 2'b01) begin
               failures++;
               $display("FAIL std_almost_full got f=%b af=%b exp 0 1", s_full, s_afull);
            end
         end
      end
      checks++;
      if ({s_full, s_afull, s_pfull, s_cnt} !== {1'b1, 1'b1, 1'b1, 5'd16}) begin
         failures++;
         $display("FAIL std_full got f=%b af=%b pf=%b cnt=%0d exp 1 1 1 16",
                  s_full, s_afull, s_pfull, s_cnt);
      end
      s_wr_data = 32'hDEAD_BEEF;
      tick();
      checks++;
      if ({s_ovf, s_wr_ack, s_cnt} !== {1'b1, 1'b0, 5'd16}) begin
         failures++;
         $display("FAIL std_overflow got ovf=%b ack=%b cnt=%0d exp 1 0 16",
                  s_ovf, s_wr_ack, s_cnt);
      end
      s_wr_en = 1'b0;
      tick();
      checks++;
      if (s_ovf !== 1'b0) begin
         failures++;
         $display("FAIL std_overflow_pulse got ovf=%b exp 0", s_ovf);
      end
      s_rd_en = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         tick();
         checks++;
         if (sq.size() == 0 || s_rd_valid !== 1'b1 || s_rd_data !== sq[0]) begin
            failures++;
            $display("FAIL std_read[%0d] got v=%b d=%h exp 1 %h",
                     i, s_rd_valid, s_rd_data, (sq.size() != 0) ? sq[0] : 32'hx);
         end
         if (sq.size() != 0) last = sq.pop_front();
      end
      s_rd_en = 1'b0;
      tick();
      checks++;
      if ({s_rd_valid, s_empty, s_cnt, s_rd_data} !== {1'b0, 1'b1, 5'd0, last}) begin
         failures++;
         $display("FAIL std_after_read got v=%b e=%b cnt=%0d d=%h exp 0 1 0 %h",
                  s_rd_valid, s_empty, s_cnt, s_rd_data, last);
      end
   endtask

   task automatic test_underflow;
      s_rd_en = 1'b1;
      f_rd_en = 1'b1;
      tick();
      s_rd_en = 1'b0;
      f_rd_en = 1'b0;
      checks++;
      if ({s_udf, s_cnt, s_rd_valid} !== {1'b1, 5'd0, 1'b0}) begin
         failures++;
         $display("FAIL std_underflow got u=%b cnt=%0d v=%b exp 1 0 0",
                  s_udf, s_cnt, s_rd_valid);
      end
      checks++;
      if ({f_udf, f_cnt, f_rd_valid} !== {1'b1, 5'd0, 1'b0}) begin
         failures++;
         $display("FAIL fwft_underflow got u=%b cnt=%0d v=%b exp 1 0 0",
                  f_udf, f_cnt, f_rd_valid);
      end
      tick();
      checks++;
      if ({s_udf, f_udf} !== 2'b00) begin
         failures++;
         $display("FAIL underflow_pulse got s=%b f=%b exp 0 0", s_udf, f_udf);
      end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 10; i++) begin
         f_wr_en = 1'b1;
         f_wr_data = 32'hC000_0000 + i;
         fq.push_back(f_wr_data);
         tick();
      end
      f_wr_en = 1'b0;
      tick();
      checks++;
      if ({f_cnt, f_rd_valid, f_pfull, f_pempty} !== {5'd10, 1'b1, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL b2b_prefill got cnt=%0d v=%b pf=%b pe=%b exp 10 1 1 1",
                  f_cnt, f_rd_valid, f_pfull, f_pempty);
      end
      for (int i = 0; i < 20; i++) begin
         f_wr_en = 1'b1;
         f_rd_en = 1'b1;
         f_wr_data = $urandom;
         checks++;
         if (fq.size() == 0 || f_rd_valid !== 1'b1 || f_rd_data !== fq[0]) begin
            failures++;
            $display("FAIL b2b_data[%0d] got v=%b d=%h exp 1 %h",
                     i, f_rd_valid, f_rd_data, (fq.size() != 0) ? fq[0] : 32'hx);
         end
         fq.push_back(f_wr_data);
         tick();
         if (fq.size() != 0) void'(fq.pop_front());
         checks++;
         if ({f_cnt, f_pfull, f_pempty, f_wr_ack} !== {5'd10, 1'b1, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL b2b_flags[%0d] got cnt=%0d pf=%b pe=%b ack=%b exp 10 1 1 1",
                     i, f_cnt, f_pfull, f_pempty, f_wr_ack);
         end
      end
      f_wr_en = 1'b0;
      for (int i = 0; i < 20 && fq.size() != 0; i++) begin
         checks++;
         if (f_rd_valid !== 1'b1 || f_rd_data !== fq[0]) begin
            failures++;
            $display("FAIL b2b_drain[%0d] got v=%b d=%h exp 1 %h",
                     i, f_rd_valid, f_rd_data, fq[0]);
         end
         tick();
         void'(fq.pop_front());
      end
      f_rd_en = 1'b0;
      checks++;
      if ({f_cnt, f_empty, f_rd_valid} !== {5'd0, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL b2b_end got cnt=%0d e=%b v=%b exp 0 1 0",
                  f_cnt, f_empty, f_rd_valid);
      end
   endtask

   task automatic test_mid_reset;
      for (int i = 0; i < 7; i++) begin
         s_wr_en = 1'b1;
         s_wr_data = $urandom;
         sq.push_back(s_wr_data);
         tick();
      end
      checks++;
      if (s_cnt !== 5'd7) begin
         failures++;
         $display("FAIL mid_rst_pre got cnt=%0d exp 7", s_cnt);
      end
      s_rst = 1'b1;
      tick();
      sq.delete();
      s_rst = 1'b0;
      s_wr_en = 1'b0;
      checks++;
      if ({s_cnt, s_empty, s_wr_ack, s_busy} !== {5'd0, 1'b1, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL mid_rst got cnt=%0d e=%b ack=%b busy=%b exp 0 1 0 1",
                  s_cnt, s_empty, s_wr_ack, s_busy);
      end
      tick();
      checks++;
      if ({s_busy, s_cnt, s_empty} !== {1'b0, 5'd0, 1'b1}) begin
         failures++;
         $display("FAIL mid_rst_release got busy=%b cnt=%0d e=%b exp 0 0 1",
                  s_busy, s_cnt, s_empty);
      end
   endtask

   initial begin
      test_reset();
      test_fwft_stream();
      test_std_fill();
      test_underflow();
      test_back_to_back();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
